background_fetch: RTL
=====================

// Module: background_fetch
// PURPOSE
// - Background pixel-fetch pipeline feeding background_ram: converts VGA DrawX/DrawY plus
//   per-frame scroll into a tile-map lookup, then into a tile-graphics read_address.
// - Captures the 5-bit palette index returned by background_ram and presents it, with
//   valid/opaque flags, to the colour mapper at a fixed 4-cycle latency.
// - Tile graphics: NUM_TILES tiles of 16x16 px, tile t occupies addresses t*256 .. t*256+255.
// PARAMETERS
// - MAP_W           64   tile-map width in tiles (world width = MAP_W*16 px)
// - MAP_H           32   tile-map height in tiles (world height = MAP_H*16 px)
// - MAP_AW          11   tile-map address width; 2**MAP_AW >= MAP_W*MAP_H
// - NUM_TILES       24   valid tile ids 0..NUM_TILES-1
// - TRANSPARENT_IDX 0    palette index meaning "no background"
// PORTS
// - Clk              in   1       system clock, all state on posedge
// - Reset            in   1       asynchronous, active-high
// - DrawX            in   10      screen x, 0..639
// - DrawY            in   10      screen y, 0..479
// - pixel_en         in   1       1 = DrawX/DrawY is a visible pixel this cycle
// - frame_start      in   1       1-cycle pulse at start of vertical blank
// - scroll_x_in      in   12      requested world x of screen column 0
// - scroll_y_in      in   12      requested world y of screen row 0
// - map_addr         out  MAP_AW  tile-map RAM address (registered)
// - map_data         in   5       tile id from tile-map RAM, valid 1 cycle after map_addr
// - bg_read_address  out  19      to background_ram read_address (registered)
// - bg_data          in   5       background_ram data_Out, valid 1 cycle after bg_read_address
// - pix_index        out  5       palette index for the pixel presented 4 cycles earlier
// - pix_valid        out  1       pix_index corresponds to a pixel_en=1 input
// - pix_opaque       out  1       pix_valid && pix_index != TRANSPARENT_IDX
// BEHAVIOUR
// - Reset: map_addr, bg_read_address, pix_index = 0; pix_valid, pix_opaque = 0;
//   scroll shadows = 0; all pipeline valid bits = 0. Reset mid-frame flushes the pipeline;
//   no stale pixel emerges after release.
// - Scroll shadow: on frame_start, scroll_x_q <= scroll_x_in if scroll_x_in < MAP_W*16, else
//   unchanged; same for y against MAP_H*16. Shadows never change outside frame_start.
// - S0 (edge N): wx = DrawX + scroll_x_q; if wx >= MAP_W*16 then wx -= MAP_W*16 (single
//   subtract suffices, both terms < width). Same for wy with MAP_H*16. Register
//   map_addr = (wy>>4)*MAP_W + (wx>>4); carry px=wx[3:0], py=wy[3:0], v0=pixel_en.
// - S1 (edge N+1): map RAM registers; carry px,py,v1=v0.
// - S2 (edge N+2): if map_data < NUM_TILES: bg_read_address = map_data*256 + py*16 + px,
//   bad=0; else bg_read_address = py*16 + px, bad=1. Carry v2=v1.
// - S3 (edge N+3): background_ram registers bg_data; carry bad, v3=v2.
// - S4 (edge N+4): pix_valid = v3; pix_index = (v3 && !bad) ? bg_data : TRANSPARENT_IDX;
//   pix_opaque = v3 && !bad && bg_data != TRANSPARENT_IDX.
// - Latency exactly 4 cycles input->pix_*; throughput 1 pixel/cycle, no stalls.
// - pixel_en=0 still drives addresses (don't-care values) but yields pix_valid=0, pix_index=
//   TRANSPARENT_IDX.
// - frame_start coincident with pixel_en=1: pixel uses OLD shadow; new value from next cycle.
// - Block never writes background_ram; write port tied off by the parent.
// TESTING
// - Reset then scroll 0, DrawX=17, DrawY=5, pixel_en=1 -> map_addr=1; map_data=3 ->
//   bg_read_address=849; bg_data=7 -> pix_index=7, pix_valid=1, pix_opaque=1 at edge N+4.
// - frame_start with scroll_x_in=1020, scroll_y_in=500; DrawX=10, DrawY=20 -> wx=6, wy=8,
//   map_addr=0, bg_read_address=map_data*256+134.
// - map_data=24 (>=NUM_TILES), bg_data=9 -> pix_index=0, pix_opaque=0, pix_valid=1.
// - scroll_x_in=1024 at frame_start after shadow=100 -> shadow stays 100; scroll_x_in change
//   without frame_start -> no effect on map_addr.
// - Stream 640 pixels with pixel_en toggling -> pix_valid equals pixel_en delayed 4 cycles.
// - Assert Reset mid-stream for 1 cycle -> all outputs 0 immediately; pix_valid stays 0 for
//   4 cycles after release unless new pixel_en=1 inputs.

Source files
------------

// File: rtl/background_fetch.sv
// -----------------------------------------------------------------------------
// background_fetch
//
// Background pixel-fetch pipeline. It turns the VGA beam position and the
// per-frame scroll into a tile-map lookup, and the returned tile id into a
// tile-graphics address for background_ram. The palette index returned by
// background_ram is presented to the colour mapper exactly 4 cycles after the
// pixel entered. Throughput is one pixel per cycle and the pipeline never
// stalls.
//
// Tile graphics: tile t occupies addresses t*256 .. t*256+255 (16x16 px).
//
// Ports
//   Clk, Reset        clock; asynchronous active-high reset
//   DrawX, DrawY      screen position of the pixel entering this cycle
//   pixel_en          1 = DrawX/DrawY is a visible pixel
//   frame_start       1-cycle pulse at start of vertical blank (loads scroll)
//   scroll_x_in/_y_in requested world position of screen pixel (0,0)
//   map_addr          tile-map RAM address (registered)
//   map_data          tile id, valid 1 cycle after map_addr
//   bg_read_address   background_ram read address (registered)
//   bg_data           background_ram data, valid 1 cycle after the address
//   pix_index         palette index of the pixel presented 4 cycles earlier
//   pix_valid         pix_index belongs to a pixel_en=1 input
//   pix_opaque        pix_valid and pix_index != TRANSPARENT_IDX
// -----------------------------------------------------------------------------
module background_fetch #(
   parameter int unsigned MAP_W           = 64,
   parameter int unsigned MAP_H           = 32,
   parameter int unsigned MAP_AW          = 11,
   parameter int unsigned NUM_TILES       = 24,
   parameter int unsigned TRANSPARENT_IDX = 0
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              pixel_en,
   input  logic              frame_start,
   input  logic [11:0]       scroll_x_in,
   input  logic [11:0]       scroll_y_in,
   output logic [MAP_AW-1:0] map_addr,
   input  logic [4:0]        map_data,
   output logic [18:0]       bg_read_address,
   input  logic [4:0]        bg_data,
   output logic [4:0]        pix_index,
   output logic              pix_valid,
   output logic              pix_opaque
);

   // World dimensions in pixels; 13 bits covers DrawX + scroll before wrap.
   localparam logic [12:0] WORLD_W     = 13'(MAP_W * 16);
   localparam logic [12:0] WORLD_H     = 13'(MAP_H * 16);
   localparam logic [5:0]  NUM_TILES_L = 6'(NUM_TILES);
   localparam logic [4:0]  TRANS_IDX   = 5'(TRANSPARENT_IDX);

   // Scroll shadows, only updated at frame_start
   logic [11:0]       scroll_x_q, scroll_x_d;
   logic [11:0]       scroll_y_q, scroll_y_d;

   // S0: world position and map address
   logic [12:0]       wx_sum, wy_sum, wx, wy;
   logic [MAP_AW-1:0] map_addr_q, map_addr_d;
   logic [3:0]        px0_q, py0_q;
   logic              v0_q;

   // S1: map RAM read in flight
   logic [3:0]        px1_q, py1_q;
   logic              v1_q;

   // S2: tile-graphics address
   logic              tile_ok;
   logic [18:0]       bg_addr_q, bg_addr_d;
   logic              bad2_q;
   logic              v2_q;

   // S3: background RAM read in flight
   logic              bad3_q;
   logic              v3_q;

   // S4: output register
   logic [4:0]        pix_index_q, pix_index_d;
   logic              pix_opaque_q, pix_opaque_d;
   logic              pix_valid_q;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
      scroll_x_d = scroll_x_q;
      scroll_y_d = scroll_y_q;
      // Out-of-range scroll requests are ignored rather than wrapped.
      if (frame_start && ({1'b0, scroll_x_in} < WORLD_W)) scroll_x_d = scroll_x_in;
      if (frame_start && ({1'b0, scroll_y_in} < WORLD_H)) scroll_y_d = scroll_y_in;

      // Both terms are below the world size, so one conditional subtract wraps.
      wx_sum = {3'b000, DrawX} + {1'b0, scroll_x_q};
      wy_sum = {3'b000, DrawY} + {1'b0, scroll_y_q};
      wx     = (wx_sum >= WORLD_W) ? (wx_sum - WORLD_W) : wx_sum;
      wy     = (wy_sum >= WORLD_H) ? (wy_sum - WORLD_H) : wy_sum;

      map_addr_d = MAP_AW'(32'(wy[12:4]) * MAP_W + 32'(wx[12:4]));

      // Out-of-range tile ids fall back to tile 0's row/column but are flagged
      // so the pixel comes out transparent.
      tile_ok   = ({1'b0, map_data} < NUM_TILES_L);
      bg_addr_d = tile_ok ? {6'b0, map_data, py1_q, px1_q}
                          : {11'b0, py1_q, px1_q};

      pix_index_d  = (v3_q && !bad3_q) ? bg_data : TRANS_IDX;
      pix_opaque_d = v3_q && !bad3_q && (bg_data != TRANS_IDX);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         scroll_x_q   <= '0;
         scroll_y_q   <= '0;
         map_addr_q   <= '0;
         px0_q        <= '0;
         py0_q        <= '0;
         v0_q         <= 1'b0;
         px1_q        <= '0;
         py1_q        <= '0;
         v1_q         <= 1'b0;
         bg_addr_q    <= '0;
         bad2_q       <= 1'b0;
         v2_q         <= 1'b0;
         bad3_q       <= 1'b0;
         v3_q         <= 1'b0;
         pix_index_q  <= '0;
         pix_valid_q  <= 1'b0;
         pix_opaque_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every stage samples the previous stage's old value on the same edge.
         scroll_x_q   <= scroll_x_d;
         scroll_y_q   <= scroll_y_d;
         map_addr_q   <= map_addr_d;
         px0_q        <= wx[3:0];
         py0_q        <= wy[3:0];
         v0_q         <= pixel_en;
         px1_q        <= px0_q;
         py1_q        <= py0_q;
         v1_q         <= v0_q;
         bg_addr_q    <= bg_addr_d;
         bad2_q       <= !tile_ok;
         v2_q         <= v1_q;
         bad3_q       <= bad2_q;
         v3_q         <= v2_q;
         pix_index_q  <= pix_index_d;
         pix_valid_q  <= v3_q;
         pix_opaque_q <= pix_opaque_d;
      end
   end

   assign map_addr        = map_addr_q;
   assign bg_read_address = bg_addr_q;
   assign pix_index       = pix_index_q;
   assign pix_valid       = pix_valid_q;
   assign pix_opaque      = pix_opaque_q;

endmodule
